rip_load_aligner: RTL and testbench

//  Read-side memory adapter for the RV32 load path.
//  - Accepts one load request (byte/half/word, signed/unsigned, any byte address).
//  - Issues word-aligned reads to data memory. A misaligned access that crosses a word is

---
 rtl/rip_load_aligner.sv | 191 +++++++++++++++++++
 tb/tb_rip_load_aligner.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rip_load_aligner.sv
// RV32 load aligner: splits misaligned loads into word reads, then
// merges, shifts and extends the read data into one load result.
module rip_load_aligner #(
  parameter  int ADDR_WIDTH = 32,
  localparam int B_WIDTH    = 8,
  localparam int H_WIDTH    = 16,
  localparam int W_WIDTH    = 32,
  localparam int D_WIDTH    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  mem_rd_valid,
  input  logic                  mem_rd_ready,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rsp_valid,
  input  logic [W_WIDTH-1:0]    mem_rsp_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [W_WIDTH-1:0]    rsp_data,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_WAIT0,
    S_RD1,
    S_WAIT1,
    S_ALIGN,
    S_DONE
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  state_t                  r_state;
  state_t                  w_next;
  logic [1:0]              r_off;
  logic [1:0]              r_size;
  logic                    r_uns;
  logic                    r_split;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [W_WIDTH-1:0]      r_lo;
  logic [W_WIDTH-1:0]      r_hi;
  logic                    r_mem_rd_valid;
  logic [ADDR_WIDTH-1:0]   r_mem_rd_addr;
  logic [W_WIDTH-1:0]      r_rsp_data;

  logic                    w_accept;
  logic                    w_split;
  logic [ADDR_WIDTH-1:0]   w_base;
  logic                    w_rd_hs;
  logic                    w_lo_take;
  logic                    w_hi_take;
  logic [D_WIDTH-1:0]      w_cat;
  logic [W_WIDTH-1:0]      w_shift;
  logic                    w_sext;
  logic [W_WIDTH-1:0]      w_result;

  assign req_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign rsp_valid    = (r_state == S_DONE);
  assign mem_rd_valid = r_mem_rd_valid;
  assign mem_rd_addr  = r_mem_rd_addr;
  assign rsp_data     = r_rsp_data;

  assign w_accept = req_valid && req_ready;
  assign w_base   = {req_addr[ADDR_WIDTH-1:2], 2'b00};

  // A half at offset 3 or any unaligned word spills into the next word.
  assign w_split =
    ((req_size == SZ_H) && (req_addr[1:0] == 2'd3)) ||
    (req_size[1] && (req_addr[1:0] != 2'd0));

  assign w_rd_hs = r_mem_rd_valid && mem_rd_ready;
  assign w_lo_take = (r_state == S_WAIT0) && mem_rsp_valid;
  assign w_hi_take = (r_state == S_WAIT1) && mem_rsp_valid;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RD0;
      S_RD0:   if (w_rd_hs) w_next = S_WAIT0;
      S_WAIT0: begin
        if (mem_rsp_valid) begin
          w_next = r_split ? S_RD1 : S_ALIGN;
        end
      end
      S_RD1:   if (w_rd_hs) w_next = S_WAIT1;
      S_WAIT1: if (mem_rsp_valid) w_next = S_ALIGN;
      S_ALIGN: w_next = S_DONE;
      S_DONE:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_cat   = {r_hi, r_lo};
  assign w_shift = W_WIDTH'(w_cat >> {r_off, 3'b000});

  always_comb begin
    w_result = w_shift;
    w_sext   = 1'b0;
    unique case (r_size)
      SZ_B: begin
        w_sext   = !r_uns && w_shift[B_WIDTH-1];
        w_result = {{(W_WIDTH-B_WIDTH){w_sext}},
                    w_shift[B_WIDTH-1:0]};
      end
      SZ_H: begin
        w_sext   = !r_uns && w_shift[H_WIDTH-1];
        w_result = {{(W_WIDTH-H_WIDTH){w_sext}},
                    w_shift[H_WIDTH-1:0]};
      end
      default: w_result = w_shift;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_off   <= '0;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_split <= 1'b0;
      r_base  <= '0;
    end else if (w_accept) begin
      r_off   <= req_addr[1:0];
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_split <= w_split;
      r_base  <= w_base;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lo <= '0;
      r_hi <= '0;
    end else begin
      if (w_accept) begin
        r_hi <= '0;
      end
      if (w_lo_take) begin
        r_lo <= mem_rsp_data;
      end
      if (w_hi_take) begin
        r_hi <= mem_rsp_data;
      end
    end
  end

  // Read request is raised on entry to RD0/RD1 so it is ready
  // the first cycle of the state and stays put until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_rd_valid <= 1'b0;
      r_mem_rd_addr  <= '0;
    end else begin
      if (w_accept) begin
        r_mem_rd_valid <= 1'b1;
        r_mem_rd_addr  <= w_base;
      end else if (w_lo_take && r_split) begin
        r_mem_rd_valid <= 1'b1;
        r_mem_rd_addr  <= r_base + ADDR_WIDTH'(4);
      end else if (w_rd_hs) begin
        r_mem_rd_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_data <= '0;
    end else if (r_state == S_ALIGN) begin
      r_rsp_data <= w_result;
    end
  end

endmodule

// File: tb/tb_rip_load_aligner.sv
// Directed vector bench for rip_load_aligner with a one-word
// memory responder answering the cycle after each read handshake.
module tb_rip_load_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        mem_rd_valid;
  logic        mem_rd_ready;
  logic [31:0] mem_rd_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;

  rip_load_aligner #(.ADDR_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_ready  (mem_rd_ready),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] exp;
    logic        split;
    logic [31:0] a0;
    logic [31:0] a1;
  } vec_t;

  vec_t        vt[12];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          rd_cnt;
  int          res_cnt;
  logic [31:0] rd_log[4];
  logic [31:0] res_data;
  logic [31:0] m_base;
  logic [31:0] m_lo;
  logic [31:0] m_hi;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance one clock, recording handshakes seen at the edge and
  // driving the memory response for the following cycle.
  task automatic step();
    logic        hs;
    logic [31:0] a;
    hs = mem_rd_valid && mem_rd_ready && !rst;
    a  = mem_rd_addr;
    if (hs) begin
      if (rd_cnt < 4) rd_log[rd_cnt] = a;
      rd_cnt++;
    end
    if (rsp_valid && rsp_ready && !rst) begin
      res_cnt++;
      res_data = rsp_data;
    end
    @(negedge clk);
    mem_rsp_valid = hs;
    mem_rsp_data  = hs ? ((a == m_base) ? m_lo : m_hi) : 32'h0;
  endtask

  task automatic issue(input vec_t v);
    m_base       = v.a0;
    m_lo         = v.lo;
    m_hi         = v.hi;
    rd_cnt       = 0;
    res_cnt      = 0;
    req_valid    = 1'b1;
    req_addr     = v.addr;
    req_size     = v.size;
    req_unsigned = v.uns;
    step();
    req_valid    = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    mem_rd_ready = 1'b1;
    rsp_ready    = 1'b0;
    issue(v);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
    end
    chk($sformatf("v%0d latency", idx), lat, v.split ? 5 : 3);
    chk($sformatf("v%0d data", idx), rsp_data, v.exp);
    chk($sformatf("v%0d reads", idx), rd_cnt, v.split ? 2 : 1);
    chk($sformatf("v%0d rd_addr0", idx), rd_log[0], v.a0);
    if (v.split) chk($sformatf("v%0d rd_addr1", idx), rd_log[1], v.a1);
    chk($sformatf("v%0d req_ready_busy", idx), req_ready, 1'b0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk($sformatf("v%0d results", idx), res_cnt, 1);
    chk($sformatf("v%0d req_ready_after", idx), req_ready, 1'b1);
  endtask

  initial begin
    int   n;
    vec_t v;
    vt[0]  = '{32'h100, 2'd2, 1'b0, 32'h8899AABB, 32'h0,
               32'h8899AABB, 1'b0, 32'h100, 32'h0};
    vt[1]  = '{32'h203, 2'd0, 1'b0, 32'h80112233, 32'h0,
               32'hFFFFFF80, 1'b0, 32'h200, 32'h0};
    vt[2]  = '{32'h203, 2'd0, 1'b1, 32'h80112233, 32'h0,
               32'h00000080, 1'b0, 32'h200, 32'h0};
    vt[3]  = '{32'h303, 2'd1, 1'b0, 32'hAABBCCDD, 32'h11223344,
               32'h000044AA, 1'b1, 32'h300, 32'h304};
    vt[4]  = '{32'h303, 2'd1, 1'b0, 32'hAABBCCDD, 32'h112233F4,
               32'hFFFFF4AA, 1'b1, 32'h300, 32'h304};
    vt[5]  = '{32'hFFFFFFFE, 2'd2, 1'b0, 32'h55667788, 32'h11223344,
               32'h33445566, 1'b1, 32'hFFFFFFFC, 32'h0};
    vt[6]  = '{32'h102, 2'd1, 1'b0, 32'h80011234, 32'h0,
               32'hFFFF8001, 1'b0, 32'h100, 32'h0};
    vt[7]  = '{32'h102, 2'd1, 1'b1, 32'h80011234, 32'h0,
               32'h00008001, 1'b0, 32'h100, 32'h0};
    vt[8]  = '{32'h101, 2'd1, 1'b0, 32'h12F07F34, 32'h0,
               32'hFFFFF07F, 1'b0, 32'h100, 32'h0};
    vt[9]  = '{32'h401, 2'd3, 1'b1, 32'h44332211, 32'h88776655,
               32'h55443322, 1'b1, 32'h400, 32'h404};
    vt[10] = '{32'h0, 2'd0, 1'b0, 32'h0000007F, 32'h0,
               32'h0000007F, 1'b0, 32'h0, 32'h0};
    vt[11] = '{32'h502, 2'd2, 1'b1, 32'h1234ABCD, 32'h00FF00EE,
               32'h00EE1234, 1'b1, 32'h500, 32'h504};

    rst           = 1'b1;
    req_valid     = 1'b0;
    req_addr      = '0;
    req_size      = '0;
    req_unsigned  = 1'b0;
    mem_rd_ready  = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    rsp_ready     = 1'b0;
    rd_cnt        = 0;
    res_cnt       = 0;
    res_data      = '0;
    m_base        = '0;
    m_lo          = '0;
    m_hi          = '0;
    for (int i = 0; i < 4; i++) rd_log[i] = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst req_ready", req_ready, 1'b1);
    chk("rst mem_rd_valid", mem_rd_valid, 1'b0);
    chk("rst mem_rd_addr", mem_rd_addr, 32'h0);
    chk("rst rsp_valid", rsp_valid, 1'b0);
    chk("rst rsp_data", rsp_data, 32'h0);
    chk("rst busy", busy, 1'b0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++) run_vec(i, vt[i]);

    // Read and result back-pressure on a split half load
    v = vt[3];
    mem_rd_ready = 1'b0;
    rsp_ready    = 1'b0;
    issue(v);
    for (int i = 0; i < 4; i++) begin
      chk("stall rd_valid", mem_rd_valid, 1'b1);
      chk("stall rd_addr", mem_rd_addr, 32'h300);
      chk("stall req_ready", req_ready, 1'b0);
      step();
    end
    mem_rd_ready = 1'b1;
    n = 0;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
    chk("stall rsp_seen", rsp_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold rsp_valid", rsp_valid, 1'b1);
      chk("hold rsp_data", rsp_data, 32'h000044AA);
      chk("hold req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("stall one result", res_cnt, 1);
    chk("stall result data", res_data, 32'h000044AA);
    chk("stall rsp_valid idle", rsp_valid, 1'b0);

    // Reset while waiting for the second word, then a stale response
    issue(v);
    n = 0;
    while (rd_cnt < 2 && n < 40) begin
      step();
      n++;
    end
    chk("wait1 reached", rd_cnt, 2);
    rst           = 1'b1;
    mem_rsp_valid = 1'b0;
    #1;
    chk("midrst req_ready", req_ready, 1'b1);
    chk("midrst rsp_valid", rsp_valid, 1'b0);
    chk("midrst busy", busy, 1'b0);
    step();
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEADBEEF;
    step();
    chk("stale req_ready", req_ready, 1'b1);
    chk("stale rsp_valid", rsp_valid, 1'b0);
    chk("stale busy", busy, 1'b0);
    chk("stale mem_rd_valid", mem_rd_valid, 1'b0);
    step();
    run_vec(100, vt[0]);
    run_vec(101, vt[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
